// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. The result is {hi = remainder, lo = quotient}.
// Define MIPS_DIV_ZERO_FAST_EN to finish a divide by zero in one cycle instead of running all WIDTH iterations.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  // state | meaning
  // IDLE  | waiting for start
  // BUSY  | one quotient bit per cycle, MSB first
  // DONE  | result valid, ready pulse
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   quo_q, rem_q, dvsr_q;
  logic               sgn_a_q, sgn_b_q, dz_q;
  logic [2*WIDTH-1:0] result_q;

  logic               start_ok, sgn_a_in, sgn_b_in, last_iter;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_d, quo_d, hi_d, lo_d;
  logic [2*WIDTH-1:0] result_d;

  always_comb begin
    start_ok  = start_i && !annul_i;
    sgn_a_in  = signed_div_i & opa_i[WIDTH-1];
    sgn_b_in  = signed_div_i & opb_i[WIDTH-1];
    abs_a     = sgn_a_in ? -opa_i : opa_i;
    abs_b     = sgn_b_in ? -opb_i : opb_i;
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    // The dividend register doubles as the quotient: its MSB shifts out and the new quotient bit enters at the LSB.
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    // With a zero divisor the remainder comes out as |opa|. Restoring the dividend's sign gives back the raw opa.
    hi_d     = sgn_a_q ? -rem_d : rem_d;
    lo_d     = dz_q ? {WIDTH{1'b1}} : ((sgn_a_q ^ sgn_b_q) ? -quo_d : quo_d);
    result_d = {hi_d, lo_d};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      sgn_a_q  <= 1'b0;
      sgn_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            sgn_a_q <= sgn_a_in;
            sgn_b_q <= sgn_b_in;
            dz_q    <= (opb_i == '0);
            quo_q   <= abs_a;
            dvsr_q  <= abs_b;
            rem_q   <= '0;
            cnt_q   <= '0;
`ifdef MIPS_DIV_ZERO_FAST_EN
            if (opb_i == '0) begin
              state_q  <= DONE;
              result_q <= {opa_i, {WIDTH{1'b1}}};
            end else begin
              state_q <= BUSY;
            end
`else
            state_q <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (annul_i) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_iter) begin
              state_q  <= DONE;
              result_q <= result_d;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == DONE) && !annul_i;
  assign stall_o  = ((state_q == IDLE) && start_ok) || (state_q == BUSY);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, flush/reset/back-to-back sequences, random ops vs arithmetic model.
module tb_div_unit;

`ifdef MIPS_DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, start, sdiv, annul;
  logic [31:0] opa, opb;
  logic [63:0] result;
  logic        ready, stall;

  int tests = 0;
  int fails = 0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .signed_div_i(sdiv), .annul_i(annul),
    .opa_i(opa), .opb_i(opb), .result_o(result), .ready_o(ready), .stall_o(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] q, r;
    longint sa, sb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = {32'd0, a / b};
      r = {32'd0, a % b};
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one divide, check stall through the operation, ready latency, result and the single-cycle ready pulse.
  task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp_res);
    int lat, exp_lat;
    bit stall_ok, seen;
    exp_lat = (b == 32'd0) ? ZLAT : 33;
    @(negedge clk);
    start = 1'b1; opa = a; opb = b; sdiv = s; annul = 1'b0;
    #1;
    stall_ok = (stall === 1'b1) && (ready === 1'b0);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (ready === 1'b1) begin
        seen = 1'b1;
        lat  = c;
        if (stall !== 1'b0) stall_ok = 1'b0;
      end else if (stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_result"}, result, exp_res);
    chk({nm, "_stall"}, 64'(stall_ok), 64'd1);
    @(negedge clk);
    #1;
    chk({nm, "_ready_once"}, 64'(ready), 64'd0);
  endtask

  vec_t        tbl[7];
  logic [63:0] last_res, r1, r2;
  logic [31:0] ra, rb;
  logic        rs;
  int          nrdy, c1, c2;

  initial begin
    tbl[0] = '{32'd100,        32'd7,          1'b0, 32'h0000_0002, 32'h0000_000E};
    tbl[1] = '{32'hFFFF_FFF9,  32'h0000_0002,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[2] = '{32'hFFFF_FFF9,  32'h0000_0002,  1'b0, 32'h0000_0001, 32'h7FFF_FFFC};
    tbl[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h0000_0000, 32'h8000_0000};
    tbl[4] = '{32'h1234_5678,  32'h0000_0000,  1'b0, 32'h1234_5678, 32'hFFFF_FFFF};
    tbl[5] = '{32'h1234_5678,  32'h0000_0000,  1'b1, 32'h1234_5678, 32'hFFFF_FFFF};
    tbl[6] = '{32'h8000_0005,  32'h0000_0000,  1'b1, 32'h8000_0005, 32'hFFFF_FFFF};

    rst = 1'b1; start = 1'b0; sdiv = 1'b0; annul = 1'b0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_div($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, {tbl[i].hi, tbl[i].lo});
      last_res = {tbl[i].hi, tbl[i].lo};
    end

    // Annul while BUSY: back to IDLE, no ready, result untouched.
    @(negedge clk);
    start = 1'b1; opa = 32'd1000; opb = 32'd3; sdiv = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      annul = (c == 10);
    end
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("annul_stall", 64'(stall), 64'd0);
    chk("annul_ready", 64'(ready), 64'd0);
    chk("annul_result", result, last_res);
    nrdy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (ready === 1'b1) nrdy++;
    end
    chk("annul_no_ready", 64'(nrdy), 64'd0);
    do_div("after_annul", 32'd1000, 32'd3, 1'b0, ref_div(32'd1000, 32'd3, 1'b0));

    // Reset in the middle of BUSY.
    @(negedge clk);
    start = 1'b1; opa = 32'd12345; opb = 32'd11; sdiv = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (c == 10);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_result", result, 64'd0);
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    do_div("after_rst", 32'hFFFF_FF9C, 32'd7, 1'b1, ref_div(32'hFFFF_FF9C, 32'd7, 1'b1));

    // Annul in the DONE cycle masks ready, but the result still updates.
    @(negedge clk);
    start = 1'b1; opa = 32'd77; opb = 32'd7; sdiv = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      start = 1'b0;
      annul = (c == 33);
    end
    #1;
    chk("done_annul_ready", 64'(ready), 64'd0);
    chk("done_annul_result", result, {32'd0, 32'd11});
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("done_annul_after", 64'(ready), 64'd0);

    // Back-to-back with start held high: ready in cycles 33 and 67.
    nrdy = 0; c1 = -1; c2 = -1; r1 = '0; r2 = '0;
    for (int c = 0; c <= 67; c++) begin
      @(negedge clk);
      start = 1'b1; sdiv = 1'b0;
      opa = (c == 0) ? 32'd50 : 32'd9;
      opb = (c == 0) ? 32'd5  : 32'd4;
      #1;
      if (ready === 1'b1) begin
        nrdy++;
        if (nrdy == 1) begin c1 = c; r1 = result; end
        else begin c2 = c; r2 = result; end
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_count", 64'(nrdy), 64'd2);
    chk("b2b_cycle1", 64'(c1), 64'd33);
    chk("b2b_res1", r1, {32'd0, 32'd10});
    chk("b2b_cycle2", 64'(c2), 64'd67);
    chk("b2b_res2", r2, {32'd1, 32'd2});
    repeat (2) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      do_div($sformatf("rnd%0d", i), ra, rb, rs, ref_div(ra, rb, rs));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
